sound_recorder_ring: RTL and testbench

- Parametrised successor recorder for the AD7673 front end: paces conversions, handshakes CNVST_N/BUSY, stores the selected ADC bits into an internal dual-port buffer, and serves reads to the parent module.
- Adds one-shot and ring (circular) capture, configurable width/depth/rate, BUSY synchronisation, conversion timeout, overrun detection and sample counting.
- Sits between the ADC pins and the playback/host logic.

---
 rtl/sound_recorder_ring.sv | 229 ++++++++++++++++++++++
 tb/tb_sound_recorder_ring.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_recorder_ring.sv
`default_nettype none
// ============================================================================
// sound_recorder_ring : AD7673 capture pacer with one-shot/ring sample buffer
// Revision 1.0
// ============================================================================
module sound_recorder_ring #(
    parameter int ADC_WIDTH           = 18,
    parameter int DATA_WIDTH          = 10,
    parameter int DATA_LSB            = 0,
    parameter int ADDR_WIDTH          = 16,
    parameter int SAMPLE_INTERVAL_CLK = 3000,
    parameter int CNVST_LOW_CLK       = 4,
    parameter int TIMEOUT_CLK         = 1024
) (
    input  logic                  clk,
    input  logic                  reset_clk,
    input  logic                  record_n,
    input  logic                  ring_mode,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic                  full,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  BUSY,
    input  logic [ADC_WIDTH-1:0]  AD7673_DATA,
    output logic                  CNVST_N
);

    localparam int c_DEPTH  = 1 << ADDR_WIDTH;
    localparam int c_CNT_W  = $clog2(SAMPLE_INTERVAL_CLK);
    localparam int c_PH_MAX = (TIMEOUT_CLK > CNVST_LOW_CLK) ? TIMEOUT_CLK : CNVST_LOW_CLK;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_TICK_AT   = c_CNT_W'(SAMPLE_INTERVAL_CLK - 1);
    localparam logic [c_PH_W-1:0]   c_LOW_LAST  = c_PH_W'(CNVST_LOW_CLK - 1);
    localparam logic [c_PH_W-1:0]   c_TO_LAST   = c_PH_W'(TIMEOUT_CLK - 1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_CONV_LOW     = 3'd1,
        S_WAIT_BUSY_HI = 3'd2,
        S_WAIT_BUSY_LO = 3'd3,
        S_WRITE        = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [c_PH_W-1:0]       ph_q, ph_d;
    logic [c_CNT_W-1:0]      int_q, int_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    cnvst_q, cnvst_d;
    logic                    overrun_q, overrun_d;
    logic                    terr_q, terr_d;
    logic                    ring_q, ring_d;
    logic                    busy_meta_q, busy_s_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   mem_q [c_DEPTH];

    logic                    w_full;
    logic                    w_stopped;
    logic                    w_tick;
    logic                    w_we;
    logic                    w_unused_adc;

    // Only the stored slice of the ADC word is used; the rest is folded here.
    assign w_unused_adc = ^AD7673_DATA;

    assign w_full    = (count_q == c_DEPTH_CNT);
    assign w_stopped = w_full && !ring_q;
    assign w_tick    = !record_n && !w_stopped && (int_q == c_TICK_AT);

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= BUSY;
            busy_s_q    <= busy_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        int_d     = int_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        cnvst_d   = cnvst_q;
        overrun_d = overrun_q;
        terr_d    = terr_q;
        ring_d    = ring_q;
        w_we      = 1'b0;

        if (record_n) begin
            int_d = '0;
        end else if (!w_stopped) begin
            int_d = w_tick ? '0 : int_q + 1'b1;
        end

        if (w_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnvst_d = 1'b1;
                ring_d  = ring_mode;
                if (w_tick) begin
                    state_d = S_CONV_LOW;
                    cnvst_d = 1'b0;
                    ph_d    = '0;
                end
            end
            S_CONV_LOW: begin
                if (ph_q == c_LOW_LAST) begin
                    state_d = S_WAIT_BUSY_HI;
                    cnvst_d = 1'b1;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WAIT_BUSY_HI: begin
                if (busy_s_q) begin
                    state_d = S_WAIT_BUSY_LO;
                    ph_d    = '0;
                end else if (ph_q == c_TO_LAST) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WAIT_BUSY_LO: begin
                if (!busy_s_q) begin
                    state_d = S_WRITE;
                    ph_d    = '0;
                end else if (ph_q == c_TO_LAST) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WRITE: begin
                w_we    = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                state_d = S_IDLE;
                if (!w_full) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnvst_d = 1'b1;
            end
        endcase

        // clear aborts any conversion in flight, including a pending write.
        if (clear) begin
            state_d   = S_IDLE;
            cnvst_d   = 1'b1;
            ph_d      = '0;
            int_d     = '0;
            wptr_d    = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            terr_d    = 1'b0;
            w_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            int_q     <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            cnvst_q   <= 1'b1;
            overrun_q <= 1'b0;
            terr_q    <= 1'b0;
            ring_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            int_q     <= int_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            cnvst_q   <= cnvst_d;
            overrun_q <= overrun_d;
            terr_q    <= terr_d;
            ring_q    <= ring_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[wptr_q] <= AD7673_DATA[DATA_LSB +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= mem_q[read_pointer];
            rvalid_q <= ({1'b0, read_pointer} < count_q);
        end
    end

    assign read_data     = rdata_q;
    assign read_valid    = rvalid_q;
    assign write_pointer = wptr_q;
    assign sample_count  = count_q;
    assign full          = w_full;
    assign overrun       = overrun_q;
    assign timeout_err   = terr_q;
    assign CNVST_N       = cnvst_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_recorder_ring.sv
`default_nettype none
// ============================================================================
// tb_sound_recorder_ring : directed/randomised bench with ADC and buffer model
// Revision 1.0
// ============================================================================
module tb_sound_recorder_ring;

    localparam int AW    = 3;
    localparam int DW    = 10;
    localparam int AWID  = 18;
    localparam int DEPTH = 1 << AW;

    logic            clk;
    logic            reset_clk;
    logic            record_n;
    logic            ring_mode;
    logic            clear;
    logic [AW-1:0]   read_pointer;
    logic [DW-1:0]   read_data;
    logic            read_valid;
    logic [AW-1:0]   write_pointer;
    logic [AW:0]     sample_count;
    logic            full;
    logic            overrun;
    logic            timeout_err;
    logic            BUSY;
    logic [AWID-1:0] AD7673_DATA;
    logic            CNVST_N;

    sound_recorder_ring #(
        .ADC_WIDTH(AWID), .DATA_WIDTH(DW), .DATA_LSB(0), .ADDR_WIDTH(AW),
        .SAMPLE_INTERVAL_CLK(20), .CNVST_LOW_CLK(2), .TIMEOUT_CLK(16)
    ) dut (
        .clk(clk), .reset_clk(reset_clk), .record_n(record_n), .ring_mode(ring_mode),
        .clear(clear), .read_pointer(read_pointer), .read_data(read_data),
        .read_valid(read_valid), .write_pointer(write_pointer),
        .sample_count(sample_count), .full(full), .overrun(overrun),
        .timeout_err(timeout_err), .BUSY(BUSY), .AD7673_DATA(AD7673_DATA),
        .CNVST_N(CNVST_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ADC model configuration and buffer reference model
    bit              adc_never = 1'b0;
    int              adc_hold  = 6;
    int              abort_gen = 0;
    int              cnv_falls = 0;
    int              completions = 0;
    logic [AWID-1:0] adc_q[$];
    logic [DW-1:0]   ref_mem [DEPTH];
    int              ref_wp = 0;
    int              ref_cnt = 0;

    initial begin : adc_model
        logic [AWID-1:0] v;
        int g;
        BUSY = 1'b0;
        AD7673_DATA = '0;
        forever begin
            @(negedge CNVST_N);
            cnv_falls++;
            g = abort_gen;
            if (!adc_never) begin
                repeat (3) @(posedge clk);
                #2 BUSY = 1'b1;
                repeat (adc_hold) @(posedge clk);
                v = (adc_q.size() > 0) ? adc_q.pop_front() : AWID'($urandom);
                #2 AD7673_DATA = v;
                BUSY = 1'b0;
                if (g == abort_gen) begin
                    ref_mem[ref_wp] = v[DW-1:0];
                    ref_wp  = (ref_wp + 1) % DEPTH;
                    ref_cnt = (ref_cnt < DEPTH) ? ref_cnt + 1 : DEPTH;
                    completions++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_falls(input int target, input int budget);
        int i = 0;
        while (cnv_falls < target && i < budget) begin
            step(1);
            i++;
        end
        chk("wait_cnvst_fall", 32'(cnv_falls >= target), 1);
    endtask

    // Record until n more samples complete; optionally stop recording afterwards.
    task automatic capture(input int n, input bit stop_after, input int budget);
        int target = completions + n;
        int i = 0;
        record_n = 1'b0;
        while (completions < target && i < budget) begin
            step(1);
            i++;
        end
        chk("wait_capture", 32'(completions >= target), 1);
        if (stop_after) record_n = 1'b1;
        step(6);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        abort_gen++;
        ref_wp  = 0;
        ref_cnt = 0;
        step(1);
        clear = 1'b0;
    endtask

    task automatic rd(input int addr, input string tag);
        read_pointer = AW'(addr);
        step(1);
        chk({tag, "_valid"}, 32'(read_valid), 32'(addr < ref_cnt));
        if (addr < ref_cnt) chk({tag, "_data"}, 32'(read_data), 32'(ref_mem[addr]));
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_wp"},   32'(write_pointer), 32'(ref_wp));
        chk({tag, "_cnt"},  32'(sample_count),  32'(ref_cnt));
        chk({tag, "_full"}, 32'(full),          32'(ref_cnt == DEPTH));
    endtask

    initial begin : stimulus
        int f0;
        int c0;
        int i;
        logic [AWID-1:0] v;

        reset_clk = 1'b0;
        record_n = 1'b1;
        ring_mode = 1'b0;
        clear = 1'b0;
        read_pointer = '0;
        #2 reset_clk = 1'b1;
        step(2);
        chk("rst_cnvst",   32'(CNVST_N), 1);
        chk("rst_wp",      32'(write_pointer), 0);
        chk("rst_cnt",     32'(sample_count), 0);
        chk("rst_full",    32'(full), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_rdata",   32'(read_data), 0);
        chk("rst_rvalid",  32'(read_valid), 0);
        reset_clk = 1'b0;
        step(2);

        // One-shot capture of 1..8 with random upper ADC bits
        for (int n = 1; n <= 8; n++) begin
            v = {8'($urandom), 10'(n)};
            adc_q.push_back(v);
        end
        capture(8, 1'b0, 8 * 25 + 40);
        chk_state("oneshot");
        chk("oneshot_full", 32'(full), 1);
        chk("oneshot_cnt8", 32'(sample_count), 8);
        f0 = cnv_falls;
        step(60);
        chk("oneshot_no_more_cnvst", 32'(cnv_falls), 32'(f0));
        read_pointer = 3'd5;
        step(1);
        chk("oneshot_rd5_data",  32'(read_data), 32'h006);
        chk("oneshot_rd5_valid", 32'(read_valid), 1);
        for (int a = 0; a < DEPTH; a++) rd(a, $sformatf("oneshot_rd%0d", a));
        record_n = 1'b1;
        step(2);

        // Ring wrap: 11 samples of 0x10+n
        ring_mode = 1'b1;
        do_clear();
        chk_state("clear1");
        for (int n = 0; n < 11; n++) begin
            v = {8'($urandom), 10'(16 + n)};
            adc_q.push_back(v);
        end
        capture(11, 1'b1, 11 * 25 + 40);
        chk("ring_wp3",   32'(write_pointer), 3);
        chk("ring_cnt8",  32'(sample_count), 8);
        chk("ring_full",  32'(full), 1);
        read_pointer = 3'd2;
        step(1);
        chk("ring_rd2", 32'(read_data), 32'h01A);
        read_pointer = 3'd3;
        step(1);
        chk("ring_rd3_oldest", 32'(read_data), 32'h013);

        // Further random ring traffic checked against the reference buffer
        capture(2 + int'($urandom_range(0, 5)), 1'b1, 8 * 25 + 40);
        chk_state("ring_rand");
        for (int k = 0; k < 6; k++) begin
            i = int'($urandom_range(0, DEPTH - 1));
            rd(i, $sformatf("ring_rand_rd%0d", i));
        end

        // Timeout: BUSY never rises
        do_clear();
        capture(2, 1'b1, 2 * 25 + 40);
        adc_never = 1'b1;
        record_n = 1'b0;
        wait_falls(cnv_falls + 1, 40);
        i = 0;
        while (CNVST_N !== 1'b1 && i < 10) begin
            step(1);
            i++;
        end
        chk("to_cnvst_release", 32'(CNVST_N), 1);
        step(15);
        chk("to_not_yet", 32'(timeout_err), 0);
        step(1);
        chk("to_at_16", 32'(timeout_err), 1);
        chk("to_wp_unchanged", 32'(write_pointer), 32'(ref_wp));
        adc_never = 1'b0;
        wait_falls(cnv_falls + 1, 25);
        capture(1, 1'b1, 40);
        chk_state("to_after");

        // Overrun: BUSY held for 15 clocks
        adc_hold = 15;
        do_clear();
        chk("clr_timeout", 32'(timeout_err), 0);
        f0 = cnv_falls;
        c0 = completions;
        capture(2, 1'b1, 2 * 45 + 40);
        chk("ovr_flag",      32'(overrun), 1);
        chk("ovr_timeout",   32'(timeout_err), 0);
        chk("ovr_one_per_2", 32'(cnv_falls - f0), 32'(completions - c0));
        chk_state("ovr");
        do_clear();
        chk("ovr_clear_flag", 32'(overrun), 0);
        chk("ovr_clear_wp",   32'(write_pointer), 0);
        chk("ovr_clear_cnt",  32'(sample_count), 0);
        adc_hold = 6;

        // record_n rises while in WAIT_BUSY_LO: sample still written
        capture(1, 1'b1, 40);
        record_n = 1'b0;
        wait_falls(cnv_falls + 1, 40);
        c0 = completions;
        i = 0;
        while (BUSY !== 1'b1 && i < 10) begin
            step(1);
            i++;
        end
        step(3);
        record_n = 1'b1;
        step(12);
        chk("stop_written", 32'(completions - c0), 1);
        chk_state("stop");
        f0 = cnv_falls;
        step(60);
        chk("stop_no_cnvst", 32'(cnv_falls), 32'(f0));

        // Asynchronous reset mid CONV_LOW
        record_n = 1'b0;
        wait_falls(cnv_falls + 1, 40);
        #2 reset_clk = 1'b1;
        abort_gen++;
        ref_wp = 0;
        ref_cnt = 0;
        #1;
        chk("arst_cnvst",  32'(CNVST_N), 1);
        chk("arst_wp",     32'(write_pointer), 0);
        chk("arst_cnt",    32'(sample_count), 0);
        chk("arst_overrun",32'(overrun), 0);
        chk("arst_rvalid", 32'(read_valid), 0);
        record_n = 1'b1;
        step(3);
        reset_clk = 1'b0;
        step(15);
        chk_state("arst_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
